// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one external combinational ALU: arbitrate, register operands,
// capture the ALU outputs one cycle later and return them on the winner's response channel.
module alu_share_ctrl #(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter bit ILLEGAL_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_funct,
  input  logic [4:0]  req0_shamt,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_funct,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nx;
  logic        owner;
  logic        last_served;
  logic        grant;
  logic        accept;
  logic        rsp_done;
  logic        legal;
  logic [31:0] result_q;
  logic [3:0]  flags_q;

  // grant = 1 selects req1; on a tie in round-robin mode the requester not served last wins
  always_comb begin
    grant = 1'b0;
    if (req1_valid && !req0_valid)
      grant = 1'b1;
    else if (req0_valid && req1_valid && !FIXED_PRIO)
      grant = ~last_served;
  end

  always_comb begin
    legal = 1'b0;
    case (alu_funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = !reset && req0_valid && !grant;
        req1_ready = !reset && req1_valid && grant;
        if (req0_ready || req1_ready)
          state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp0_valid = !reset && !owner;
        rsp1_valid = !reset && owner;
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept   = req0_ready || req1_ready;
  assign rsp_done = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      owner       <= 1'b0;
      alu_funct   <= '0;
      alu_shamt   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner     <= grant;
        alu_funct <= grant ? req1_funct : req0_funct;
        alu_shamt <= grant ? req1_shamt : req0_shamt;
        alu_a     <= grant ? req1_a     : req0_a;
        alu_b     <= grant ? req1_b     : req0_b;
      end
      if (state == EXEC) begin
        if (ILLEGAL_ERR && !legal) begin
          result_q <= '0;
          flags_q  <= 4'b1000;
        end else begin
          result_q <= alu_result;
          flags_q  <= {1'b0, alu_ovf, alu_zero, alu_carry};
        end
      end
      if (rsp_done)
        last_served <= owner;
    end
  end

  // Both channels show the shared capture register; only the owner's valid qualifies it
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_flags  = flags_q;
  assign rsp1_flags  = flags_q;
  assign busy        = (state != IDLE);

endmodule
